// File: rtl/fir_input_sequencer.sv
// fir_input_sequencer: sample FIFO plus coefficient sequencer that feeds the
// FIR filter. Requests to the filter are paced by its modwait busy signal.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer; wait for modwait=0, then pick coefficients or a sample
// C_REQ  | load_coeff asserted with coeff[ci]; wait for modwait=1
// C_WAIT | filter is taking coefficient ci; wait for modwait=0
// S_REQ  | data_ready asserted with the popped sample; wait for modwait=1
// S_WAIT | filter is taking the sample; wait for modwait=0
module fir_input_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] sample_in,
  input  logic        sample_push,
  input  logic [15:0] coeff_in,
  input  logic [1:0]  coeff_addr,
  input  logic        coeff_wr,
  input  logic        coeff_start,
  input  logic        clr_overrun,
  input  logic        modwait,
  output logic [15:0] sample_data,
  output logic        data_ready,
  output logic [15:0] fir_coefficient,
  output logic        load_coeff,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        coeff_busy,
  output logic        overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    C_REQ  = 3'd1,
    C_WAIT = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  // storage and state
  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [15:0] r_coeff [4];
  state_t      r_state;
  logic [1:0]  r_ci;
  logic        r_busy;
  logic        r_overrun;

  // registered outputs
  logic [15:0] r_sample_data;
  logic        r_data_ready;
  logic [15:0] r_fir_coefficient;
  logic        r_load_coeff;
  logic        r_fifo_full;
  logic        r_fifo_empty;

  // combinational helpers
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_coeff_done;
  logic [CW-1:0] w_count_nxt;
  state_t        w_state_nxt;
  logic [1:0]    w_ci_nxt;
  logic          w_data_ready_nxt;
  logic          w_load_coeff_nxt;
  logic [15:0]   w_fir_coeff_nxt;
  logic [15:0]   w_sample_nxt;

  // Fullness is judged on the pre-edge count, so a push on a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = sample_push & ~w_full;
  assign w_pop        = (r_state == IDLE) & ~modwait & ~r_busy & ~w_empty;
  assign w_coeff_done = (r_state == C_WAIT) & ~modwait & (r_ci == 2'd3);

  // occupancy after this edge
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO data array (no reset needed, contents qualified by the count)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= sample_in;
    end
  end

  // FIFO pointers, count, status flags and the sticky overrun flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_fifo_full  <= 1'b0;
      r_fifo_empty <= 1'b1;
      r_overrun    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count      <= w_count_nxt;
      r_fifo_full  <= (w_count_nxt == CW'(DEPTH));
      r_fifo_empty <= (w_count_nxt == '0);
      if (sample_push && w_full) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // coefficient registers and the pending/busy flag; writes locked out while busy
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_coeff[0] <= '0;
      r_coeff[1] <= '0;
      r_coeff[2] <= '0;
      r_coeff[3] <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (coeff_wr && !r_busy) begin
        r_coeff[coeff_addr] <= coeff_in;
      end
      if (!r_busy && coeff_start) begin
        r_busy <= 1'b1;
      end else if (w_coeff_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_ci    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ci    <= w_ci_nxt;
    end
  end

  // FSM next-state logic; a pending coefficient load wins over queued samples
  always_comb begin
    w_state_nxt = r_state;
    w_ci_nxt    = r_ci;
    case (r_state)
      IDLE: begin
        if (!modwait) begin
          if (r_busy) begin
            w_state_nxt = C_REQ;
            w_ci_nxt    = 2'd0;
          end else if (!w_empty) begin
            w_state_nxt = S_REQ;
          end
        end
      end
      C_REQ: begin
        if (modwait) begin
          w_state_nxt = C_WAIT;
        end
      end
      C_WAIT: begin
        if (!modwait) begin
          if (r_ci == 2'd3) begin
            w_state_nxt = IDLE;
          end else begin
            w_ci_nxt    = r_ci + 2'd1;
            w_state_nxt = C_REQ;
          end
        end
      end
      S_REQ: begin
        if (modwait) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!modwait) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output decode, registered below so the filter sees clean flop outputs
  always_comb begin
    w_data_ready_nxt = (r_state == S_REQ);
    w_load_coeff_nxt = (r_state == C_REQ);
    w_fir_coeff_nxt  = r_fir_coefficient;
    w_sample_nxt     = r_sample_data;
    if (r_state == C_REQ) begin
      w_fir_coeff_nxt = r_coeff[r_ci];
    end
    if (w_pop) begin
      w_sample_nxt = r_mem[r_rptr];
    end
  end

  // output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data_ready      <= 1'b0;
      r_load_coeff      <= 1'b0;
      r_fir_coefficient <= '0;
      r_sample_data     <= '0;
    end else begin
      r_data_ready      <= w_data_ready_nxt;
      r_load_coeff      <= w_load_coeff_nxt;
      r_fir_coefficient <= w_fir_coeff_nxt;
      r_sample_data     <= w_sample_nxt;
    end
  end

  assign sample_data     = r_sample_data;
  assign data_ready      = r_data_ready;
  assign fir_coefficient = r_fir_coefficient;
  assign load_coeff      = r_load_coeff;
  assign fifo_full       = r_fifo_full;
  assign fifo_empty      = r_fifo_empty;
  assign coeff_busy      = r_busy;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Bench for fir_input_sequencer: directed steps plus a random-timing filter
// responder; every handshake seen by the responder is compared against the
// transfer order predicted by a queue model.
module tb_fir_input_sequencer;

  logic        clk;
  logic        n_rst;
  logic [15:0] sample_in;
  logic        sample_push;
  logic [15:0] coeff_in;
  logic [1:0]  coeff_addr;
  logic        coeff_wr;
  logic        coeff_start;
  logic        clr_overrun;
  logic        modwait;
  logic [15:0] sample_data;
  logic        data_ready;
  logic [15:0] fir_coefficient;
  logic        load_coeff;
  logic        fifo_full;
  logic        fifo_empty;
  logic        coeff_busy;
  logic        overrun;

  logic r_auto;
  logic r_mw_man;
  logic r_mw_auto;
  logic r_resp_err;

  int n_assert;
  int n_fail;

  // transfers as {is_coeff, value}
  logic [16:0] obs_q [$];
  logic [16:0] exp_q [$];

  assign modwait = r_auto ? r_mw_auto : r_mw_man;

  fir_input_sequencer #(.DEPTH(8)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .sample_in       (sample_in),
    .sample_push     (sample_push),
    .coeff_in        (coeff_in),
    .coeff_addr      (coeff_addr),
    .coeff_wr        (coeff_wr),
    .coeff_start     (coeff_start),
    .clr_overrun     (clr_overrun),
    .modwait         (modwait),
    .sample_data     (sample_data),
    .data_ready      (data_ready),
    .fir_coefficient (fir_coefficient),
    .load_coeff      (load_coeff),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .coeff_busy      (coeff_busy),
    .overrun         (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // filter model: answers each request after a random delay and holds busy a random time
  initial begin
    r_mw_auto  = 1'b0;
    r_resp_err = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (r_auto && !r_mw_auto && (data_ready || load_coeff)) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #2;
        if (load_coeff) obs_q.push_back({1'b1, fir_coefficient});
        else            obs_q.push_back({1'b0, sample_data});
        r_mw_auto = 1'b1;
        for (int k = 0; k < 20 && (data_ready || load_coeff); k++) begin
          @(posedge clk);
          #2;
        end
        if (data_ready || load_coeff) r_resp_err = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #2;
        r_mw_auto = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_obs(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_count"}, obs_q.size(), n);
  endtask

  task automatic compare_q(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check(tag, {15'd0, obs_q[i]}, {15'd0, exp_q[i]});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic push(input logic [15:0] v);
    sample_in   = v;
    sample_push = 1'b1;
    tick();
    sample_push = 1'b0;
  endtask

  task automatic wcoeff(input logic [1:0] a, input logic [15:0] v);
    coeff_addr = a;
    coeff_in   = v;
    coeff_wr   = 1'b1;
    tick();
    coeff_wr   = 1'b0;
  endtask

  task automatic pulse_start();
    coeff_start = 1'b1;
    tick();
    coeff_start = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_load_coeff", load_coeff, 1'b0);
    check("rst_sample_data", sample_data, 16'h0);
    check("rst_fir_coeff", fir_coefficient, 16'h0);
    check("rst_fifo_empty", fifo_empty, 1'b1);
    check("rst_fifo_full", fifo_full, 1'b0);
    check("rst_coeff_busy", coeff_busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  initial begin
    logic [15:0] v [9];
    logic [15:0] c [4];
    int k;
    n_assert    = 0;
    n_fail      = 0;
    r_auto      = 1'b0;
    r_mw_man    = 1'b0;
    n_rst       = 1'b1;
    sample_in   = '0;
    sample_push = 1'b0;
    coeff_in    = '0;
    coeff_addr  = '0;
    coeff_wr    = 1'b0;
    coeff_start = 1'b0;
    clr_overrun = 1'b0;
    #2;
    do_reset();

    // single sample with a hand-driven filter
    push(16'h1234);
    check("single_not_empty", fifo_empty, 1'b0);
    tick();
    check("single_data", sample_data, 16'h1234);
    check("single_dr_lag", data_ready, 1'b0);
    tick();
    check("single_dr_high", data_ready, 1'b1);
    tick();
    tick();
    r_mw_man = 1'b1;
    tick();
    check("single_dr_hold", data_ready, 1'b1);
    tick();
    check("single_dr_drop", data_ready, 1'b0);
    repeat (3) tick();
    r_mw_man = 1'b0;
    tick();
    tick();
    check("single_data_held", sample_data, 16'h1234);
    check("single_empty", fifo_empty, 1'b1);
    check("single_dr_idle", data_ready, 1'b0);

    // reset in the middle of a sample request
    push(16'hBEEF);
    tick();
    tick();
    check("mid_dr_high", data_ready, 1'b1);
    do_reset();

    // fill, overflow, sticky overrun and its clear
    r_mw_man = 1'b1;
    for (int i = 0; i < 9; i++) begin
      v[i] = 16'($urandom);
      push(v[i]);
      if (i == 7) begin
        check("full_after_8", fifo_full, 1'b1);
        check("no_overrun_8", overrun, 1'b0);
      end
    end
    check("overrun_after_9", overrun, 1'b1);
    check("still_full", fifo_full, 1'b1);
    sample_push = 1'b1;
    clr_overrun = 1'b1;
    tick();
    sample_push = 1'b0;
    check("overrun_set_wins", overrun, 1'b1);
    tick();
    clr_overrun = 1'b0;
    check("overrun_cleared", overrun, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, v[i]});
    r_mw_man = 1'b0;
    r_auto   = 1'b1;
    wait_obs("drain", 8, 200);
    compare_q("drain_order");
    repeat (12) tick();
    check("drain_empty", fifo_empty, 1'b1);

    // coefficient load of 1..4
    r_auto = 1'b0;
    for (int a = 0; a < 4; a++) wcoeff(2'(a), 16'(a + 1));
    pulse_start();
    check("coeff_busy_set", coeff_busy, 1'b1);
    for (int a = 0; a < 4; a++) exp_q.push_back({1'b1, 16'(a + 1)});
    r_auto = 1'b1;
    wait_obs("coeff", 4, 200);
    check("coeff_busy_4th", coeff_busy, 1'b1);
    compare_q("coeff_order");
    k = 0;
    while (coeff_busy && k < 30) begin
      tick();
      k++;
    end
    check("coeff_busy_fall", coeff_busy, 1'b0);
    repeat (4) tick();

    // reset must clear the coefficient registers
    r_auto = 1'b0;
    do_reset();
    pulse_start();
    for (int a = 0; a < 4; a++) exp_q.push_back({1'b1, 16'h0});
    r_auto = 1'b1;
    wait_obs("coeff_zero", 4, 200);
    compare_q("coeff_zero_val");
    repeat (12) tick();

    // priority: coefficient start during a sample's wait, write locked out
    r_auto = 1'b0;
    r_mw_man = 1'b0;
    for (int a = 0; a < 4; a++) begin
      c[a] = 16'($urandom);
      wcoeff(2'(a), c[a]);
    end
    for (int i = 0; i < 3; i++) begin
      v[i] = 16'($urandom);
      push(v[i]);
    end
    k = 0;
    while (!data_ready && k < 20) begin
      tick();
      k++;
    end
    check("prio_dr", data_ready, 1'b1);
    check("prio_first", sample_data, v[0]);
    r_mw_man = 1'b1;
    tick();
    tick();
    check("prio_in_wait", data_ready, 1'b0);
    pulse_start();
    check("prio_busy", coeff_busy, 1'b1);
    wcoeff(2'd2, ~c[2]);
    for (int a = 0; a < 4; a++) exp_q.push_back({1'b1, c[a]});
    exp_q.push_back({1'b0, v[1]});
    exp_q.push_back({1'b0, v[2]});
    r_mw_man = 1'b0;
    r_auto   = 1'b1;
    wait_obs("prio", 6, 300);
    compare_q("prio_order");
    repeat (12) tick();
    check("prio_idle_busy", coeff_busy, 1'b0);
    check("prio_empty", fifo_empty, 1'b1);

    // wrap-around stream with random gaps
    for (int i = 0; i < 20; i++) begin
      logic [15:0] d;
      repeat ($urandom_range(0, 3)) tick();
      k = 0;
      while (fifo_full && k < 50) begin
        tick();
        k++;
      end
      d = 16'($urandom);
      exp_q.push_back({1'b0, d});
      push(d);
    end
    wait_obs("wrap", 20, 600);
    compare_q("wrap_order");
    repeat (12) tick();
    check("wrap_empty", fifo_empty, 1'b1);
    check("wrap_no_overrun", overrun, 1'b0);
    check("resp_timeout", r_resp_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_input_sequencer.md
# fir_input_sequencer

Upstream feeder for the FIR filter stage. It buffers incoming audio samples in a small FIFO and sequences a four-word coefficient set into the filter. It drives the filter's `sample_data`/`data_ready` and `fir_coefficient`/`load_coeff` inputs under a handshake paced by the filter's `modwait`, so the producer never has to track filter busy time.

## Interface
- `DEPTH`, 8: sample FIFO depth in entries; must be a power of two, ≥2.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `n_rst`  in  1: reset, asynchronous, active-low.
- `sample_in`  in  16: sample from the producer.
- `sample_push`  in  1: single-cycle strobe that writes `sample_in` into the FIFO.
- `coeff_in`  in  16: coefficient write data.
- `coeff_addr`  in  2: coefficient register index, 0–3.
- `coeff_wr`  in  1: writes `coeff_in` into coefficient register `coeff_addr`.
- `coeff_start`  in  1: single-cycle request to load all four registers into the filter.
- `clr_overrun`  in  1: clears `overrun`.
- `modwait`  in  1: filter busy indication, taken from the filter output.
- `sample_data`  out  16: sample presented to the filter.
- `data_ready`  out  1: sample request to the filter.
- `fir_coefficient`  out  16: coefficient presented to the filter.
- `load_coeff`  out  1: coefficient request to the filter.
- `fifo_full`, `fifo_empty`  out  1 each: FIFO status.
- `coeff_busy`  out  1: high while a coefficient load is pending or in progress.
- `overrun`  out  1: sticky flag, set when a push is dropped.

## Operation
- **Outputs and reset.** All outputs are registered. Reset values:
  - `sample_data` = 0, `fir_coefficient` = 0.
  - `data_ready`, `load_coeff`, `coeff_busy`, `overrun`, `fifo_full` = 0; `fifo_empty` = 1.
  - FIFO pointers and count = 0; coefficient registers = 0; state = IDLE.
- **FIFO.** Circular buffer of `DEPTH` × 16 bits.
  - Read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`. The count is `$clog2(DEPTH)+1` bits wide.
  - A push while full is dropped and sets `overrun`. Fullness is judged on the pre-edge count, so the push is dropped even if a pop happens in the same cycle.
  - A push and a pop in the same cycle on a non-full FIFO leave the count unchanged.
  - `overrun` holds until `clr_overrun`. If a drop and `clr_overrun` coincide, the set wins.
- **Coefficient registers.**
  - `coeff_wr` is honoured only while `coeff_busy`=0; otherwise it is ignored.
  - `coeff_start` sets a pending flag and `coeff_busy`=1 on the next edge. It is ignored while `coeff_busy`=1.
- **FSM states:** IDLE, C_REQ, C_WAIT, S_REQ, S_WAIT, with a 2-bit coefficient index `ci`.
- **From IDLE** (only when `modwait`=0):
  - If pending: go to C_REQ with `ci`=0. Coefficient load has priority over samples.
  - Else if FIFO not empty: pop the head into `sample_data` and go to S_REQ.
- **C_REQ:**
  - `fir_coefficient` = coeff[`ci`], `load_coeff`=1.
  - Go to C_WAIT on the first edge where `modwait`=1.
- **C_WAIT:**
  - `load_coeff`=0.
  - On `modwait`=0: if `ci`=3, clear pending, set `coeff_busy`=0 and go to IDLE. Otherwise increment `ci` and go to C_REQ.
- **S_REQ:**
  - `data_ready`=1 and `sample_data` held stable.
  - Go to S_WAIT on `modwait`=1.
- **S_WAIT:**
  - `data_ready`=0 and `sample_data` held.
  - Go to IDLE on `modwait`=0.
- **No timeout.** The request stays asserted indefinitely until the filter responds.
- **Reset mid-operation** aborts any transfer immediately. No partial coefficient set is resumed after reset.

## Timing
- **Push to pop.** A sample pushed at edge N is eligible for pop at edge N+1. From an empty, idle state with `modwait`=0, `data_ready` is high after edge N+2.
- **Handshake.** `data_ready` and `load_coeff` deassert on the edge after `modwait` is first sampled high. The next request is launched no earlier than two edges after `modwait` is sampled low: one edge to return to IDLE, one to issue.
- **Coefficient load.** Minimum duration is 4 × (REQ + WAIT + IDLE-free step), with one filter handshake per word, issued in index order 0, 1, 2, 3.
- **Sample/coefficient interleave.** A `coeff_start` arriving during a sample transfer takes effect after that transfer returns to IDLE. It never interrupts the transfer.

## Test plan
- **Reset and idle.**
  - Stimulus: assert `n_rst`=0 mid-S_REQ.
  - Required response: `data_ready`=0 immediately, `fifo_empty`=1, all outputs at their reset values.
- **Single sample.**
  - Stimulus: push 0x1234; model `modwait` rising 2 cycles after `data_ready` and falling 5 cycles later.
  - Required response: `sample_data`=0x1234 throughout; `data_ready` drops one edge after `modwait` rises; `fifo_empty`=1 afterwards.
- **Full and overrun.**
  - Stimulus: push 9 samples with `modwait` held 1.
  - Required response: `fifo_full`=1 after the 8th push; the 9th push is dropped and `overrun`=1; the first 8 values drain in order; `clr_overrun` clears the flag.
- **Coefficient load.**
  - Stimulus: write 0x0001, 0x0002, 0x0003, 0x0004 to addresses 0–3, then pulse `coeff_start`.
  - Required response: four `load_coeff` handshakes presenting 1, 2, 3, 4 in order; `coeff_busy` falls after the 4th handshake's `modwait` fall.
- **Priority and lockout.**
  - Stimulus: queue 3 samples and pulse `coeff_start` during the first sample's S_WAIT; attempt `coeff_wr` during the load.
  - Required response: the first sample completes, then all 4 coefficients load, then the remaining 2 samples follow; the write during the load is ignored.
- **Wrap-around.**
  - Stimulus: stream 20 sequential values through the FIFO with interleaved pushes and pops, including same-cycle push and pop.
  - Required response: the output order matches the input order with no loss; the count stays consistent.
